// File: rtl/imem_fetch.sv
// Instruction memory with a one-cycle fetch port and byte-enabled program-load port.
// Optional boot image selected by defining IMEM_BOOT_PRELOAD_EN.
module imem_fetch #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_instr,
    output logic [1:0]        resp_fault,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic [3:0]        wr_be,
    output logic              init_done
);

    localparam int          AW  = $clog2(DEPTH);
    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_cnt;
    logic [AW-1:0]   w_cnt_nxt;
    logic [31:0]     r_mem [DEPTH];
    logic [31:0]     w_init_word;
    logic [AW-1:0]   w_ridx;
    logic [AW-1:0]   w_widx;
    logic [1:0]      w_fault;
    logic            w_accept;
    logic            r_resp_valid;
    logic [31:0]     r_resp_instr;
    logic [1:0]      r_resp_fault;

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return (addr >> (AW + 2)) == '0;
    endfunction

`ifdef IMEM_BOOT_PRELOAD_EN
    function automatic logic [31:0] boot_word(input logic [AW-1:0] idx);
        if (idx == AW'(0))      return 32'hFFC4A303;
        else if (idx == AW'(1)) return 32'h413903B3;
        else if (idx == AW'(2)) return 32'h00940333;
        else                    return NOP;
    endfunction
`endif

    always_comb begin
`ifdef IMEM_BOOT_PRELOAD_EN
        w_init_word = boot_word(r_cnt);
`else
        w_init_word = NOP;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // INIT sweeps every word once, then the FSM parks in RUN.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (r_state == ST_INIT) begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (r_cnt == AW'(DEPTH - 1)) begin
                w_state_nxt = ST_RUN;
            end
        end
    end

    assign init_done  = (r_state == ST_RUN);
    assign req_ready  = init_done & (~r_resp_valid | resp_ready);
    assign w_accept   = req_valid & req_ready;
    assign w_ridx     = req_addr[AW+1:2];
    assign w_widx     = wr_addr[AW+1:2];
    assign w_fault    = (req_addr[1:0] != 2'b00) ? 2'd1 :
                        (!in_range(req_addr))    ? 2'd2 : 2'd0;

    // Memory array has no reset; its contents come only from the INIT sweep.
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_mem[r_cnt] <= w_init_word;
        end else if (wr_en && in_range(wr_addr)) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    r_mem[w_widx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Read samples the array before this edge's write lands, giving old data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_resp_valid <= 1'b0;
            r_resp_instr <= '0;
            r_resp_fault <= '0;
        end else if (w_accept) begin
            r_resp_valid <= 1'b1;
            r_resp_fault <= w_fault;
            r_resp_instr <= (w_fault != 2'd0) ? NOP : r_mem[w_ridx];
        end else if (resp_ready) begin
            r_resp_valid <= 1'b0;
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_instr = r_resp_instr;
    assign resp_fault = r_resp_fault;

endmodule

// File: tb/tb_imem_fetch.sv
// Bench for imem_fetch: behavioural memory/response model compared every cycle,
// plus literal checks of init timing, faults, byte writes, stalls and reset.
module tb_imem_fetch;

    localparam int          DEPTH = 64;
    localparam logic [31:0] NOP   = 32'h00000013;
`ifdef IMEM_BOOT_PRELOAD_EN
    localparam logic [31:0] W0 = 32'hFFC4A303;
    localparam logic [31:0] W1 = 32'h413903B3;
    localparam logic [31:0] W2 = 32'h00940333;
`else
    localparam logic [31:0] W0 = NOP;
    localparam logic [31:0] W1 = NOP;
    localparam logic [31:0] W2 = NOP;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        resp_ready = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_be = '0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_instr;
    logic [1:0]  resp_fault;
    logic        init_done;

    int n_cmp = 0;
    int n_err = 0;

    imem_fetch #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_instr(resp_instr), .resp_fault(resp_fault),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem [DEPTH];
    int          m_rel = 0;
    logic        m_v = 1'b0;
    logic [31:0] m_i = '0;
    logic [1:0]  m_f = '0;

    function automatic logic [31:0] boot(input int k);
        if (k == 0) return W0;
        if (k == 1) return W1;
        if (k == 2) return W2;
        return NOP;
    endfunction

    function automatic logic [1:0] fault_of(input logic [31:0] a);
        if (a[1:0] != 2'b00) return 2'd1;
        if (a >= 32'(4 * DEPTH)) return 2'd2;
        return 2'd0;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_rel = 0;
            m_v   = 1'b0;
            m_i   = '0;
            m_f   = '0;
            for (int k = 0; k < DEPTH; k++) m_mem[k] = boot(k);
        end else begin
            logic done, rdy;
            done = (m_rel >= DEPTH);
            rdy  = done && (!m_v || resp_ready);
            if (req_valid && rdy) begin
                m_f = fault_of(req_addr);
                if (m_f != 2'd0) m_i = NOP;
                else             m_i = m_mem[req_addr / 4];
                m_v = 1'b1;
            end else if (resp_ready) begin
                m_v = 1'b0;
            end
            if (done && wr_en && wr_addr < 32'(4 * DEPTH)) begin
                for (int b = 0; b < 4; b++)
                    if (wr_be[b]) m_mem[wr_addr / 4][8*b +: 8] = wr_data[8*b +: 8];
            end
            if (m_rel < DEPTH) m_rel++;
        end
    end

    always @(negedge clk) begin
        logic done_e, rdy_e;
        done_e = reset && (m_rel >= DEPTH);
        rdy_e  = done_e && (!m_v || resp_ready);
        check("cyc_init_done", 32'(init_done), 32'(done_e));
        check("cyc_req_ready", 32'(req_ready), 32'(rdy_e));
        check("cyc_resp_valid", 32'(resp_valid), 32'(m_v));
        check("cyc_resp_instr", resp_instr, m_i);
        check("cyc_resp_fault", 32'(resp_fault), 32'(m_f));
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        int sel;
        logic [31:0] w;
        sel = $urandom_range(0, 15);
        if (sel == 0) return $urandom;
        w = 32'($urandom_range(0, DEPTH + 3) * 4);
        if (sel == 1) w = w + 32'($urandom_range(1, 3));
        return w;
    endfunction

    task automatic randomize_inputs();
        req_valid  = ($urandom_range(0, 3) != 0);
        req_addr   = rand_addr();
        resp_ready = ($urandom_range(0, 3) != 0);
        wr_en      = ($urandom_range(0, 4) == 0);
        wr_addr    = rand_addr();
        wr_data    = $urandom;
        wr_be      = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_init();
        req_valid  = 1'b1;
        req_addr   = '0;
        resp_ready = 1'b1;
        wr_en      = 1'b1;
        wr_addr    = '0;
        wr_data    = 32'hCAFEF00D;
        wr_be      = 4'hF;
        for (int i = 0; i < DEPTH; i++) begin
            check("init_done_low", 32'(init_done), 32'd0);
            check("ready_in_init", 32'(req_ready), 32'd0);
            if (i == DEPTH - 1) begin
                req_valid = 1'b0;
                wr_en     = 1'b0;
            end
            step();
        end
        check("init_done_high", 32'(init_done), 32'd1);
    endtask

    task automatic fetch1(input logic [31:0] a, input logic [31:0] ei, input logic [1:0] ef, input string nm);
        req_valid  = 1'b1;
        req_addr   = a;
        resp_ready = 1'b1;
        step();
        req_valid = 1'b0;
        check({nm, "_valid"}, 32'(resp_valid), 32'd1);
        check({nm, "_instr"}, resp_instr, ei);
        check({nm, "_fault"}, 32'(resp_fault), 32'(ef));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp4 [4];
        exp4[0] = W0; exp4[1] = W1; exp4[2] = W2; exp4[3] = NOP;

        step();
        step();
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_instr", resp_instr, 32'd0);
        check("rst_fault", 32'(resp_fault), 32'd0);
        reset = 1'b1;
        wait_init();

        // back-to-back aligned fetches
        req_valid  = 1'b1;
        resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_addr = 32'(4 * k);
            step();
            check("b2b_valid", 32'(resp_valid), 32'd1);
            check("b2b_instr", resp_instr, exp4[k]);
            check("b2b_fault", 32'(resp_fault), 32'd0);
        end
        req_valid = 1'b0;
        step();

        fetch1(32'd6,   NOP, 2'd1, "mis6");
        fetch1(32'd256, NOP, 2'd2, "oor256");
        fetch1(32'd258, NOP, 2'd1, "mis258");

        // byte-enabled write with same-cycle fetch of the same word
        wr_en     = 1'b1;
        wr_addr   = 32'd16;
        wr_data   = 32'hDEADBEEF;
        wr_be     = 4'b0011;
        req_valid = 1'b1;
        req_addr  = 32'd16;
        resp_ready = 1'b1;
        step();
        wr_en     = 1'b0;
        req_valid = 1'b0;
        check("rbw_instr", resp_instr, NOP);
        fetch1(32'd16, 32'h0000BEEF, 2'd0, "be_write");
        fetch1(32'd1024, NOP, 2'd2, "oor1024");

        // stall with consumer not ready
        req_valid  = 1'b1;
        req_addr   = 32'd0;
        resp_ready = 1'b0;
        step();
        req_addr = 32'd4;
        for (int k = 0; k < 3; k++) begin
            check("stall_ready", 32'(req_ready), 32'd0);
            check("stall_valid", 32'(resp_valid), 32'd1);
            check("stall_instr", resp_instr, W0);
            step();
        end
        resp_ready = 1'b1;
        #1;
        check("release_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        check("release_valid", 32'(resp_valid), 32'd1);
        check("release_instr", resp_instr, W1);
        step();

        for (int n = 0; n < 1500; n++) begin
            randomize_inputs();
            step();
        end

        // reset while a response is pending
        req_valid  = 1'b1;
        req_addr   = 32'd8;
        resp_ready = 1'b0;
        wr_en      = 1'b0;
        step();
        req_valid = 1'b0;
        check("pre_rst_valid", 32'(resp_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_valid", 32'(resp_valid), 32'd0);
        check("async_rst_instr", resp_instr, 32'd0);
        check("async_rst_done", 32'(init_done), 32'd0);
        check("async_rst_ready", 32'(req_ready), 32'd0);
        step();
        step();
        reset = 1'b1;
        wait_init();
        fetch1(32'd8, W2, 2'd0, "post_rst");
        fetch1(32'd16, NOP, 2'd0, "post_rst_reinit");

        for (int n = 0; n < 400; n++) begin
            randomize_inputs();
            step();
        end
        req_valid = 1'b0;
        wr_en     = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imem_fetch.md
IMEM_FETCH -- requirements
Module: imem_fetch

Interface
REQ-001 Parameter DEPTH, default 64: instruction memory depth in 32-bit words; power of two, minimum 8.
REQ-002 Parameter ADDR_W, default 32: byte-address width of the fetch and write ports.
REQ-003 clk  input  1  single clock; every flop is rising-edge triggered.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  fetch request present.
REQ-006 req_ready  output  1  fetch request accepted this cycle when req_valid is also high.
REQ-007 req_addr  input  ADDR_W  fetch byte address (PC).
REQ-008 resp_valid  output  1  response present.
REQ-009 resp_ready  input  1  consumer takes the response this cycle.
REQ-010 resp_instr  output  32  fetched instruction word, little-endian byte order.
REQ-011 resp_fault  output  2  fault code: 0 = ok, 1 = misaligned, 2 = out of range.
REQ-012 wr_en  input  1  program-load write strobe.
REQ-013 wr_addr  input  ADDR_W  write byte address; bits [1:0] ignored.
REQ-014 wr_data  input  32  write data.
REQ-015 wr_be  input  4  byte enables; bit i enables byte i.
REQ-016 init_done  output  1  memory initialisation complete.

Function
REQ-017 Word index = addr[log2(DEPTH)+1:2]; an address is in range when addr < 4*DEPTH.
REQ-018 FSM states: INIT and RUN. Reset enters INIT with word counter = 0. INIT writes one word per cycle at index counter, then increments the counter. After the write to index DEPTH-1, the FSM moves to RUN on the next edge and init_done rises (DEPTH cycles after reset release).
REQ-019 In INIT: req_ready = 0, and wr_en is ignored.
REQ-020 req_ready = init_done AND (NOT resp_valid OR resp_ready); this gives throughput of one fetch per cycle.
REQ-021 Read latency is exactly one cycle: an accepted request produces resp_valid = 1 on the next cycle.
REQ-022 resp_valid, resp_instr and resp_fault hold stable while resp_valid = 1 and resp_ready = 0.
REQ-023 resp_valid clears on the cycle after resp_ready = 1 unless a new request is accepted in that same cycle.
REQ-024 Fault priority: misaligned (req_addr[1:0] != 0) takes precedence over out of range; any fault returns resp_instr = 32'h00000013 (NOP).
REQ-025 In-range writes in RUN update only the enabled bytes; out-of-range writes are dropped silently.
REQ-026 A fetch and a write to the same word in the same cycle return the old data (read-before-write).

Reset
REQ-027 Asserting reset asynchronously forces: state = INIT, counter = 0, init_done = 0, resp_valid = 0, resp_instr = 0, resp_fault = 0, req_ready = 0.
REQ-028 Reset mid-operation discards any pending response; initialisation restarts from index 0.
REQ-029 Memory contents are defined only by the INIT sequence; contents before INIT completes are unspecified.

Configuration
REQ-030 Macro IMEM_BOOT_PRELOAD_EN defined: INIT writes word 0 = 32'hFFC4A303, word 1 = 32'h413903B3, word 2 = 32'h00940333, and 32'h00000013 to all other words.
REQ-031 Macro not defined: INIT writes 32'h00000013 to every word.

Verification
REQ-032 Release reset with DEPTH = 64 -> init_done = 0 for 64 cycles, then 1; req_ready = 0 throughout INIT.
REQ-033 With IMEM_BOOT_PRELOAD_EN, fetch addresses 0, 4, 8, 12 back-to-back with resp_ready = 1 -> responses on consecutive cycles: FFC4A303, 413903B3, 00940333, 00000013, all with fault 0.
REQ-034 Fetch address 6 -> fault 1 with NOP; fetch address 256 -> fault 2 with NOP; fetch address 258 -> fault 1.
REQ-035 Write 32'hDEADBEEF to address 16 with wr_be = 4'b0011, then fetch 16 -> 0000BEEF (no preload); a same-cycle fetch of 16 returns 00000013.
REQ-036 Hold resp_ready = 0 for 3 cycles with req_valid high -> req_ready = 0, response stable; on resp_ready = 1 the next request is accepted in that same cycle.
REQ-037 Assert reset while resp_valid = 1 -> resp_valid = 0 immediately; INIT restarts and init_done returns 64 cycles after release.
